// File: rtl/vio_route_stage_if.sv
// Stream bundle between the user region, the route stage and the vFPGA switch.
// The slave side carries no tdest; the route is attached inside the stage.
interface vio_route_stage_if #(
  parameter int DATA_BITS  = 512,
  parameter int ID_BITS    = 6,
  parameter int ROUTE_BITS = 14
);
  logic                    tvalid;
  logic                    tready;
  logic [DATA_BITS-1:0]    tdata;
  logic [DATA_BITS/8-1:0]  tkeep;
  logic                    tlast;
  logic [ID_BITS-1:0]      tid;
  logic [ROUTE_BITS-1:0]   tdest;

  modport master (output tvalid, tdata, tkeep, tlast, tid, tdest, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tid, output tready);
endinterface

// File: rtl/vio_route_stage.sv
// Per-region ingress stage: tags the user stream with a packet-stable route and
// presents it to the vFPGA switch through a 2-entry registered skid buffer.
module vio_route_stage #(
  parameter int DATA_BITS  = 512,
  parameter int ID_BITS    = 6,
  parameter int ROUTE_BITS = 14
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cfg_route_valid,
  output logic                  cfg_route_ready,
  input  logic [ROUTE_BITS-1:0] cfg_route_data,
  vio_route_stage_if.slave      s_axis,
  vio_route_stage_if.master     m_axis,
  output logic [ROUTE_BITS-1:0] route_active,
  output logic                  route_valid,
  output logic [31:0]           stat_pkt_cnt
);
  // state  | meaning
  // IDLE   | no route applied since reset; stream held off
  // READY  | between packets; a pending route is applied here (one-cycle bubble)
  // IN_PKT | inside a packet; route frozen, pending route waits for tlast
  typedef enum logic [1:0] {IDLE, READY, IN_PKT} state_t;

  localparam int KEEP_BITS = DATA_BITS / 8;
  localparam int BEAT_BITS = DATA_BITS + KEEP_BITS + 1 + ID_BITS + ROUTE_BITS;

  state_t                state, state_nxt;
  logic                  pend_v;
  logic [ROUTE_BITS-1:0] pend_r;
  logic [ROUTE_BITS-1:0] route_cur;
  logic                  apply;
  logic                  rx_open;
  logic                  s_ready;
  logic                  accept;
  logic                  out_v;
  logic                  skid_v;
  logic [BEAT_BITS-1:0]  in_beat;
  logic [BEAT_BITS-1:0]  out_beat;
  logic [BEAT_BITS-1:0]  skid_beat;
  logic [31:0]           pkt_cnt;

  // Skid occupied means both entries hold data, so ready depends only on state.
  assign s_ready = rx_open && !skid_v;
  assign accept  = s_axis.tvalid && s_ready;
  assign in_beat = {s_axis.tdata, s_axis.tkeep, s_axis.tlast, s_axis.tid, route_cur};

  always_comb begin
    state_nxt = state;
    apply     = 1'b0;
    rx_open   = 1'b0;
    case (state)
      IDLE: begin
        if (pend_v) begin
          apply     = 1'b1;
          state_nxt = READY;
        end
      end
      READY: begin
        if (pend_v) begin
          apply = 1'b1;
        end else begin
          rx_open = 1'b1;
          if (s_axis.tvalid && !skid_v && !s_axis.tlast) state_nxt = IN_PKT;
        end
      end
      IN_PKT: begin
        rx_open = 1'b1;
        if (s_axis.tvalid && !skid_v && s_axis.tlast) state_nxt = READY;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      pend_v      <= 1'b0;
      pend_r      <= '0;
      route_cur   <= '0;
      route_valid <= 1'b0;
      pkt_cnt     <= '0;
    end else begin
      // apply implies pend_v, so a refill can never collide with the apply
      if (apply) begin
        route_cur   <= pend_r;
        route_valid <= 1'b1;
        pend_v      <= 1'b0;
      end
      if (cfg_route_valid && !pend_v) begin
        pend_v <= 1'b1;
        pend_r <= cfg_route_data;
      end
      if (accept && s_axis.tlast) pkt_cnt <= pkt_cnt + 32'd1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      out_v     <= 1'b0;
      skid_v    <= 1'b0;
      out_beat  <= '0;
      skid_beat <= '0;
    end else if (!out_v || m_axis.tready) begin
      if (skid_v) begin
        out_beat <= skid_beat;
        skid_v   <= 1'b0;
      end else if (accept) begin
        out_beat <= in_beat;
        out_v    <= 1'b1;
      end else begin
        out_v <= 1'b0;
      end
    end else if (accept) begin
      skid_beat <= in_beat;
      skid_v    <= 1'b1;
    end
  end

  assign s_axis.tready   = s_ready;
  assign m_axis.tvalid   = out_v;
  assign {m_axis.tdata, m_axis.tkeep, m_axis.tlast, m_axis.tid, m_axis.tdest} = out_beat;
  assign cfg_route_ready = !pend_v;
  assign route_active    = route_cur;
  assign stat_pkt_cnt    = pkt_cnt;
endmodule

// File: tb/tb_vio_route_stage.sv
// Bench for vio_route_stage: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, and a randomized traffic phase.
module tb_vio_route_stage;
  localparam int DB = 512;
  localparam int KB = DB / 8;
  localparam int IB = 6;
  localparam int RB = 14;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cfg_v = 1'b0;
  logic          cfg_rdy;
  logic [RB-1:0] cfg_d = '0;
  logic [RB-1:0] route_active;
  logic          route_valid;
  logic [31:0]   stat;

  always #5 clk = ~clk;

  vio_route_stage_if #(.DATA_BITS(DB), .ID_BITS(IB), .ROUTE_BITS(RB)) s_if ();
  vio_route_stage_if #(.DATA_BITS(DB), .ID_BITS(IB), .ROUTE_BITS(RB)) m_if ();
  assign s_if.tdest = '0;

  vio_route_stage #(.DATA_BITS(DB), .ID_BITS(IB), .ROUTE_BITS(RB)) dut (
    .aclk(clk), .aresetn(rstn),
    .cfg_route_valid(cfg_v), .cfg_route_ready(cfg_rdy), .cfg_route_data(cfg_d),
    .s_axis(s_if), .m_axis(m_if),
    .route_active(route_active), .route_valid(route_valid), .stat_pkt_cnt(stat)
  );

  typedef struct packed {
    logic [DB-1:0] d;
    logic [KB-1:0] k;
    logic          l;
    logic [IB-1:0] id;
    logic [RB-1:0] dst;
  } beat_t;

  // Reference model: beats in flight plus the route bookkeeping.
  beat_t         q[$];
  logic [RB-1:0] obs_tdest[$];
  bit            md_applied, md_pend_v, md_in_pkt, md_acc, md_cfg_acc;
  logic [RB-1:0] md_cur, md_pend;
  logic [31:0]   md_cnt;
  bit            preload_req = 1'b0;
  bit            chk_en = 1'b0;
  int            mrdy_mode = 0;
  int            n_chk = 0;
  int            n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string nm, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit exp_sready();
    return md_applied && (md_in_pkt || !md_pend_v) && (q.size() < 2);
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      q.delete();
      md_applied = 0; md_pend_v = 0; md_in_pkt = 0; md_acc = 0; md_cfg_acc = 0;
      md_cur = '0; md_pend = '0; md_cnt = '0;
    end else begin
      bit sr, acc, pop, app, cacc;
      sr   = exp_sready();
      acc  = s_if.tvalid && sr;
      pop  = (q.size() != 0) && m_if.tready;
      app  = md_pend_v && !md_in_pkt;
      cacc = cfg_v && !md_pend_v;
      if (preload_req) md_cnt = 32'hFFFF_FFFF;
      if (pop) void'(q.pop_front());
      if (acc) begin
        beat_t b;
        b.d = s_if.tdata; b.k = s_if.tkeep; b.l = s_if.tlast; b.id = s_if.tid; b.dst = md_cur;
        q.push_back(b);
        md_in_pkt = !s_if.tlast;
        if (s_if.tlast) md_cnt = md_cnt + 32'd1;
      end
      if (app) begin md_cur = md_pend; md_pend_v = 0; md_applied = 1; end
      if (cacc) begin md_pend = cfg_d; md_pend_v = 1; end
      md_acc     = acc;
      md_cfg_acc = cacc;
    end
  end

  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      chk("s_tready", 64'(s_if.tready), 64'(exp_sready()));
      chk("cfg_ready", 64'(cfg_rdy), 64'(!md_pend_v));
      chk("route_valid", 64'(route_valid), 64'(md_applied));
      chk("route_active", 64'(route_active), 64'(md_cur));
      chk("pkt_cnt", 64'(stat), 64'(md_cnt));
      chk("m_tvalid", 64'(m_if.tvalid), 64'(q.size() != 0));
      if (q.size() != 0 && m_if.tvalid) begin
        chk_w("m_tdata", m_if.tdata, q[0].d);
        chk("m_tkeep", 64'(m_if.tkeep), 64'(q[0].k));
        chk("m_tlast", 64'(m_if.tlast), 64'(q[0].l));
        chk("m_tid", 64'(m_if.tid), 64'(q[0].id));
        chk("m_tdest", 64'(m_if.tdest), 64'(q[0].dst));
      end
      if (m_if.tvalid && m_if.tready) obs_tdest.push_back(m_if.tdest);
    end
  end

  task automatic next_cycle();
    @(negedge clk);
    case (mrdy_mode)
      0:       m_if.tready = 1'b1;
      1:       m_if.tready = 1'($urandom_range(0, 1));
      default: m_if.tready = 1'b0;
    endcase
    if (md_cfg_acc) cfg_v = 1'b0;
  endtask

  task automatic rand_beat(input bit last);
    logic [DB-1:0] d;
    for (int k = 0; k < DB / 32; k++) d[k*32 +: 32] = $urandom();
    s_if.tdata  = d;
    s_if.tkeep  = {$urandom(), $urandom()};
    s_if.tid    = IB'($urandom());
    s_if.tlast  = last;
    s_if.tvalid = 1'b1;
  endtask

  task automatic send_pkt(input int n, input int cfg_at, input logic [RB-1:0] cfg_val);
    for (int i = 0; i < n; i++) begin
      int guard;
      rand_beat(i == n - 1);
      if (i == cfg_at) begin cfg_v = 1'b1; cfg_d = cfg_val; end
      guard = 0;
      do begin next_cycle(); guard++; end while (!md_acc && guard < 500);
      if (!md_acc) begin
        chk("accept_timeout", 64'd0, 64'd1);
        s_if.tvalid = 1'b0;
        return;
      end
    end
    s_if.tvalid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((m_if.tvalid || q.size() != 0 || cfg_v) && g < 300) begin next_cycle(); g++; end
    chk("drain_timeout", 64'(m_if.tvalid), 64'd0);
  endtask

  initial begin
    int base, g;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0; s_if.tid = '0;
    m_if.tready = 1'b1;
    next_cycle(); next_cycle();
    rstn = 1'b1; chk_en = 1'b1;
    #2;
    chk("rst_cfg_ready", 64'(cfg_rdy), 64'd1);
    chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst_pkt_cnt", 64'(stat), 64'd0);

    // No route yet: stream must stay blocked.
    rand_beat(1'b0);
    for (int i = 0; i < 10; i++) begin
      next_cycle(); #2;
      chk("idle_s_tready", 64'(s_if.tready), 64'd0);
    end
    chk("idle_route_valid", 64'(route_valid), 64'd0);
    s_if.tvalid = 1'b0;

    // First route and a 4-beat packet.
    base = obs_tdest.size();
    cfg_v = 1'b1; cfg_d = 14'h03FC;
    send_pkt(4, -1, '0);
    drain();
    chk("p1_count", 64'(obs_tdest.size() - base), 64'd4);
    for (int i = 0; i < 4; i++) chk("p1_tdest", 64'(obs_tdest[base+i]), 64'h03FC);
    chk("p1_pkt_cnt", 64'(stat), 64'd1);

    // Route update mid-packet: held until after tlast, then one bubble.
    base = obs_tdest.size();
    send_pkt(4, 1, 14'h0BFC);
    #2;
    chk("bubble_cfg_ready", 64'(cfg_rdy), 64'd0);
    chk("bubble_s_tready", 64'(s_if.tready), 64'd0);
    chk("bubble_route_old", 64'(route_active), 64'h03FC);
    next_cycle(); #2;
    chk("after_cfg_ready", 64'(cfg_rdy), 64'd1);
    chk("after_route_new", 64'(route_active), 64'h0BFC);
    chk("after_s_tready", 64'(s_if.tready), 64'd1);
    send_pkt(2, -1, '0);
    drain();
    for (int i = 0; i < 4; i++) chk("p2_tdest_old", 64'(obs_tdest[base+i]), 64'h03FC);
    for (int i = 4; i < 6; i++) chk("p3_tdest_new", 64'(obs_tdest[base+i]), 64'h0BFC);

    // Long packet under random backpressure.
    base = obs_tdest.size();
    mrdy_mode = 1;
    send_pkt(64, -1, '0);
    mrdy_mode = 0;
    drain();
    chk("p64_count", 64'(obs_tdest.size() - base), 64'd64);

    // Randomized traffic with random route updates.
    mrdy_mode = 1;
    for (int c = 0; c < 1500; c++) begin
      next_cycle();
      if (md_acc || !s_if.tvalid) begin
        if ($urandom_range(0, 3) != 0) rand_beat($urandom_range(0, 4) == 0);
        else s_if.tvalid = 1'b0;
      end
      if (!cfg_v && $urandom_range(0, 19) == 0) begin cfg_v = 1'b1; cfg_d = RB'($urandom()); end
    end
    mrdy_mode = 0;
    g = 0;
    while (s_if.tvalid && g < 500) begin next_cycle(); if (md_acc) s_if.tvalid = 1'b0; g++; end
    chk("rand_hold_timeout", 64'(s_if.tvalid), 64'd0);
    if (md_in_pkt) send_pkt(1, -1, '0);
    drain();

    // Reset mid-packet with both entries occupied.
    mrdy_mode = 2;
    rand_beat(1'b0);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if (md_acc) rand_beat(1'b0);
    end
    #2;
    chk("full_m_tvalid", 64'(m_if.tvalid), 64'd1);
    chk("full_s_tready", 64'(s_if.tready), 64'd0);
    next_cycle();
    rstn = 1'b0;
    next_cycle();
    rstn = 1'b1; s_if.tvalid = 1'b0; mrdy_mode = 0;
    #2;
    chk("mrst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("mrst_route_valid", 64'(route_valid), 64'd0);
    chk("mrst_pkt_cnt", 64'(stat), 64'd0);
    chk("mrst_cfg_ready", 64'(cfg_rdy), 64'd1);
    chk("mrst_s_tready", 64'(s_if.tready), 64'd0);

    // Counter wrap on a single-beat packet.
    cfg_v = 1'b1; cfg_d = 14'h1234;
    for (int i = 0; i < 3; i++) next_cycle();
    chk_en = 1'b0; preload_req = 1'b1;
    force dut.pkt_cnt = 32'hFFFF_FFFF;
    next_cycle();
    release dut.pkt_cnt;
    preload_req = 1'b0; chk_en = 1'b1;
    #2;
    chk("preload_cnt", 64'(stat), 64'hFFFF_FFFF);
    base = obs_tdest.size();
    send_pkt(1, -1, '0);
    #2;
    chk("wrap_cnt", 64'(stat), 64'd0);
    next_cycle(); #2;
    chk("wrap_ready_state", 64'(s_if.tready), 64'd1);
    drain();
    chk("wrap_tdest", 64'(obs_tdest[base]), 64'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
